// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweep of two implementations of an N_IN-input function.
// Records both tables, counts differing vectors and remembers the lowest one.
module truth_table_sweeper #(
   parameter int N_IN   = 4,
   parameter int SETTLE = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   output logic [N_IN-1:0]       vec,
   input  logic                  s_ref,
   input  logic                  s_alt,
   output logic                  busy,
   output logic                  done,
   output logic                  aborted,
   output logic [(1<<N_IN)-1:0]  table_ref,
   output logic [(1<<N_IN)-1:0]  table_alt,
   output logic [N_IN:0]         mismatch_cnt,
   output logic [N_IN-1:0]       first_bad,
   output logic                  first_bad_valid,
   output logic                  equal
);

   localparam int NV = 1 << N_IN;
   localparam logic [N_IN-1:0] LAST_VEC = N_IN'(NV - 1);
   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

   typedef enum logic [1:0] {IDLE, APPLY, FINISH} state_t;

   state_t            state_reg, state_next;
   logic [N_IN-1:0]   vec_reg, vec_next;
   logic [3:0]        cnt_reg, cnt_next;
   logic              busy_reg, busy_next;
   logic              done_reg, done_next;
   logic              aborted_reg, aborted_next;
   logic [NV-1:0]     table_ref_reg, table_ref_next;
   logic [NV-1:0]     table_alt_reg, table_alt_next;
   logic [N_IN:0]     mismatch_reg, mismatch_next;
   logic [N_IN-1:0]   first_bad_reg, first_bad_next;
   logic              fbv_reg, fbv_next;
   logic              equal_reg, equal_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         vec_reg       <= '0;
         cnt_reg       <= '0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         aborted_reg   <= 1'b0;
         table_ref_reg <= '0;
         table_alt_reg <= '0;
         mismatch_reg  <= '0;
         first_bad_reg <= '0;
         fbv_reg       <= 1'b0;
         equal_reg     <= 1'b0;
      end else begin
         state_reg     <= state_next;
         vec_reg       <= vec_next;
         cnt_reg       <= cnt_next;
         busy_reg      <= busy_next;
         done_reg      <= done_next;
         aborted_reg   <= aborted_next;
         table_ref_reg <= table_ref_next;
         table_alt_reg <= table_alt_next;
         mismatch_reg  <= mismatch_next;
         first_bad_reg <= first_bad_next;
         fbv_reg       <= fbv_next;
         equal_reg     <= equal_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      vec_next       = vec_reg;
      cnt_next       = cnt_reg;
      busy_next      = busy_reg;
      done_next      = 1'b0;
      aborted_next   = 1'b0;
      table_ref_next = table_ref_reg;
      table_alt_next = table_alt_reg;
      mismatch_next  = mismatch_reg;
      first_bad_next = first_bad_reg;
      fbv_next       = fbv_reg;
      equal_next     = equal_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next     = APPLY;
               vec_next       = '0;
               cnt_next       = '0;
               busy_next      = 1'b1;
               table_ref_next = '0;
               table_alt_next = '0;
               mismatch_next  = '0;
               first_bad_next = '0;
               fbv_next       = 1'b0;
               equal_next     = 1'b0;
            end
         end
         APPLY: begin
            // Abort wins over a sample landing on the same edge.
            if (abort) begin
               state_next   = IDLE;
               busy_next    = 1'b0;
               aborted_next = 1'b1;
            end else if (cnt_reg == SETTLE_LAST) begin
               table_ref_next[vec_reg] = s_ref;
               table_alt_next[vec_reg] = s_alt;
               if (s_ref != s_alt) begin
                  mismatch_next = mismatch_reg + (N_IN+1)'(1);
                  if (!fbv_reg) begin
                     first_bad_next = vec_reg;
                     fbv_next       = 1'b1;
                  end
               end
               if (vec_reg != LAST_VEC) begin
                  vec_next = vec_reg + N_IN'(1);
                  cnt_next = '0;
               end else begin
                  state_next = FINISH;
               end
            end else begin
               cnt_next = cnt_reg + 4'd1;
            end
         end
         FINISH: begin
            state_next = IDLE;
            busy_next  = 1'b0;
            done_next  = 1'b1;
            equal_next = (mismatch_reg == '0);
         end
         default: state_next = IDLE;
      endcase
   end

   assign vec             = vec_reg;
   assign busy            = busy_reg;
   assign done            = done_reg;
   assign aborted         = aborted_reg;
   assign table_ref       = table_ref_reg;
   assign table_alt       = table_alt_reg;
   assign mismatch_cnt    = mismatch_reg;
   assign first_bad       = first_bad_reg;
   assign first_bad_valid = fbv_reg;
   assign equal           = equal_reg;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench: two sweepers (SETTLE=1 and SETTLE=3) driving small function models;
// expected sweep results are queued at start and checked when done/aborted pulses.
module tb_truth_table_sweeper;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   typedef struct {
      logic        is_abort;
      logic        loose;
      logic [15:0] tref;
      logic [15:0] talt;
      logic [4:0]  cnt;
      logic [3:0]  fb;
      logic        fbv;
      logic        eq;
   } exp_t;

   exp_t q1[$];
   exp_t q3[$];
   int n_checks = 0;
   int n_errors = 0;
   int mode = 0;

   function automatic logic f_canon(input logic [3:0] v);
      return (v == 4'd2) || (v == 4'd4) || (v == 4'd5) || (v == 4'd7) ||
             (v == 4'd9) || (v == 4'd13) || (v == 4'd14);
   endfunction

   function automatic logic f_simp(input logic [3:0] v);
      logic a, b, c, d;
      {a, b, c, d} = v;
      return (!a && b && !c) || (!a && b && d) || (a && !c && d) ||
             (!a && !b && c && !d) || (a && b && c && !d);
   endfunction

   // DUT with SETTLE=1
   logic start1 = 0, abort1 = 0;
   logic [3:0] vec1, fb1;
   logic busy1, done1, aborted1, fbv1, eq1, sref1, salt1;
   logic [15:0] tref1, talt1;
   logic [4:0] cnt1;
   logic d1a = 0, d1b = 0;

   // DUT with SETTLE=3, alt output delayed two cycles
   logic start3 = 0, abort3 = 0;
   logic [3:0] vec3, fb3;
   logic busy3, done3, aborted3, fbv3, eq3, sref3, salt3;
   logic [15:0] tref3, talt3;
   logic [4:0] cnt3;
   logic d3a = 0, d3b = 0;

   always @(posedge clk) begin
      d1a <= f_simp(vec1);
      d1b <= d1a;
      d3a <= f_simp(vec3);
      d3b <= d3a;
   end

   assign sref1 = f_canon(vec1);
   assign salt1 = (mode == 0) ? f_simp(vec1) :
                  (mode == 1) ? ((f_simp(vec1) || vec1 == 4'd0) && vec1 != 4'd9) :
                  (mode == 2) ? ~f_canon(vec1) : d1b;
   assign sref3 = f_canon(vec3);
   assign salt3 = d3b;

   truth_table_sweeper #(.N_IN(4), .SETTLE(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .abort(abort1), .vec(vec1),
      .s_ref(sref1), .s_alt(salt1), .busy(busy1), .done(done1), .aborted(aborted1),
      .table_ref(tref1), .table_alt(talt1), .mismatch_cnt(cnt1), .first_bad(fb1),
      .first_bad_valid(fbv1), .equal(eq1));

   truth_table_sweeper #(.N_IN(4), .SETTLE(3)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .abort(abort3), .vec(vec3),
      .s_ref(sref3), .s_alt(salt3), .busy(busy3), .done(done3), .aborted(aborted3),
      .table_ref(tref3), .table_alt(talt3), .mismatch_cnt(cnt3), .first_bad(fb3),
      .first_bad_valid(fbv3), .equal(eq3));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic sb_check(input string tag, input exp_t e, input logic ab, input logic bs,
                           input logic [15:0] tr, input logic [15:0] ta, input logic [4:0] c,
                           input logic [3:0] fb, input logic fbv, input logic eq);
      $display("%s sweep end: aborted=%0b ref=%h alt=%h cnt=%0d first_bad=%0d/%0b equal=%0b",
               tag, ab, tr, ta, c, fb, fbv, eq);
      chk({tag, " kind"}, ab, e.is_abort);
      chk({tag, " busy"}, bs, 0);
      chk({tag, " table_ref"}, tr, e.tref);
      if (!e.loose) begin
         chk({tag, " table_alt"}, ta, e.talt);
         chk({tag, " mismatch_cnt"}, c, e.cnt);
         chk({tag, " first_bad"}, fb, e.fb);
      end else begin
         chk({tag, " mismatch_nonzero"}, (c != 0), 1);
      end
      chk({tag, " first_bad_valid"}, fbv, e.fbv);
      chk({tag, " equal"}, eq, e.eq);
   endtask

   always @(negedge clk) begin
      if (done1 || aborted1) begin
         if (q1.size() == 0) chk("dut1 unexpected_end", {done1, aborted1}, 0);
         else sb_check("dut1", q1.pop_front(), aborted1, busy1, tref1, talt1, cnt1, fb1, fbv1, eq1);
      end
      if (done3 || aborted3) begin
         if (q3.size() == 0) chk("dut3 unexpected_end", {done3, aborted3}, 0);
         else sb_check("dut3", q3.pop_front(), aborted3, busy3, tref3, talt3, cnt3, fb3, fbv3, eq3);
      end
   end

   function automatic exp_t mk(input logic ab, input logic loose, input logic [15:0] tr,
                               input logic [15:0] ta, input logic [4:0] c, input logic [3:0] fb,
                               input logic fbv, input logic eq);
      exp_t e;
      e.is_abort = ab; e.loose = loose; e.tref = tr; e.talt = ta;
      e.cnt = c; e.fb = fb; e.fbv = fbv; e.eq = eq;
      return e;
   endfunction

   task automatic check_zero1(input string name);
      chk(name, {vec1, busy1, done1, aborted1, tref1, talt1, cnt1, fb1, fbv1, eq1}, 0);
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic pulse_start1();
      start1 = 1;
      @(negedge clk);
      start1 = 0;
   endtask

   task automatic wait_vec1(input logic [3:0] v);
      int n = 0;
      while (vec1 !== v && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("wait_vec1", vec1, v);
   endtask

   task automatic wait_done1();
      int n = 0;
      while (done1 !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("wait_done1", done1, 1);
   endtask

   initial begin
      int n;
      logic ok;
      repeat (2) @(negedge clk);
      check_zero1("reset_outputs_dut1");
      chk("reset_outputs_dut3", {vec3, busy3, done3, aborted3, tref3, talt3, cnt3, fbv3, eq3}, 0);
      rst = 0;
      @(negedge clk);
      check_zero1("post_reset_idle");

      // Equivalent forms, with done latency measured from the accepting edge
      mode = 0;
      q1.push_back(mk(0, 0, 16'h62B4, 16'h62B4, 0, 0, 0, 1));
      pulse_start1();
      chk("busy_after_start", busy1, 1);
      n = 0;
      while (!done1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("done_latency", n, 17);

      // Back-to-back start in the done cycle, injected mismatch
      mode = 1;
      q1.push_back(mk(0, 0, 16'h62B4, 16'h60B5, 2, 0, 1, 0));
      pulse_start1();
      chk("b2b_accepted", busy1, 1);
      wait_done1();
      @(negedge clk);

      // All-differ
      mode = 2;
      q1.push_back(mk(0, 0, 16'h62B4, 16'h9D4B, 16, 0, 1, 0));
      pulse_start1();
      wait_done1();
      @(negedge clk);

      // Delayed alt with too short a settle time
      mode = 3;
      q1.push_back(mk(0, 1, 16'h62B4, 16'h0, 0, 0, 1, 0));
      pulse_start1();
      wait_done1();
      @(negedge clk);

      // SETTLE=3 with delayed alt: each vector held exactly 3 cycles
      q3.push_back(mk(0, 0, 16'h62B4, 16'h62B4, 0, 0, 0, 1));
      start3 = 1;
      @(negedge clk);
      start3 = 0;
      for (int k = 0; k < 16; k++) begin
         ok = 1;
         for (int j = 0; j < 3; j++) begin
            if (k != 0 || j != 0) @(negedge clk);
            if (vec3 !== 4'(k)) ok = 0;
         end
         chk($sformatf("settle3_hold_vec%0d", k), ok, 1);
      end
      n = 0;
      while (!done3 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("wait_done3", done3, 1);
      @(negedge clk);

      // Start while busy ignored, then abort at vec=8
      mode = 0;
      q1.push_back(mk(1, 0, 16'h00B4, 16'h00B4, 0, 0, 0, 0));
      pulse_start1();
      wait_vec1(4'd5);
      start1 = 1;
      @(negedge clk);
      start1 = 0;
      chk("start_while_busy_ignored", {busy1, vec1}, {1'b1, 4'd6});
      wait_vec1(4'd8);
      abort1 = 1;
      @(negedge clk);
      abort1 = 0;
      chk("abort_state", {busy1, aborted1, done1}, 3'b010);
      repeat (3) @(negedge clk);
      chk("abort_results_hold", {tref1, cnt1, eq1}, {16'h00B4, 5'd0, 1'b0});

      // Reset mid-sweep, then a clean full sweep
      pulse_start1();
      wait_vec1(4'd10);
      #2 rst = 1;
      #1 check_zero1("async_reset_mid_sweep");
      @(negedge clk);
      rst = 0;
      repeat (3) @(negedge clk);
      check_zero1("no_done_after_reset");
      q1.push_back(mk(0, 0, 16'h62B4, 16'h62B4, 0, 0, 0, 1));
      pulse_start1();
      wait_done1();
      repeat (2) @(negedge clk);

      chk("scoreboard_drained", {q1.size(), q3.size()}, 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
